// File: rtl/pc_call_stack.sv
// Program counter with a circular return-address stack for the 4-bit core.
// The PC is presented on the data bus one nibble per subcycle and updated once per instruction.
module pc_call_stack #(
    parameter int ADDR_NIBBLES = 3,
    parameter int DEPTH        = 3,
    parameter int LAST_CYCLE   = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [2:0]                cycle,
    input  logic [1:0]                control,
    input  logic [4*ADDR_NIBBLES-1:0] target,
    input  logic                      clear_flags,
    output logic [4*ADDR_NIBBLES-1:0] pc,
    output logic                      pc_enable,
    output logic [3:0]                pc_word,
    output logic [3:0]                depth,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int         AW           = 4 * ADDR_NIBBLES;
    localparam logic [3:0] DEPTH_MAX    = 4'(DEPTH);
    localparam logic [3:0] PTR_LAST     = 4'(DEPTH - 1);
    localparam logic [3:0] BUS_NIBBLES  = 4'(ADDR_NIBBLES);
    localparam logic [2:0] COMMIT_CYCLE = 3'(LAST_CYCLE);

    localparam logic [1:0] MODE_INC  = 2'b00;
    localparam logic [1:0] MODE_JUMP = 2'b01;
    localparam logic [1:0] MODE_CALL = 2'b10;
    localparam logic [1:0] MODE_RET  = 2'b11;

    logic [AW-1:0] pc_reg, pc_next;
    logic [3:0]    ptr_reg, ptr_next;
    logic [3:0]    depth_reg, depth_next;
    logic          overflow_reg, overflow_next;
    logic          underflow_reg, underflow_next;
    logic [AW-1:0] entry_reg [DEPTH];

    logic [AW-1:0] pc_inc;
    logic [AW-1:0] pop_value;
    logic [3:0]    ptr_inc;
    logic [3:0]    ptr_dec;
    logic          commit;
    logic          push;
    logic          pop;
    logic          stack_full;
    logic          stack_empty;
    logic [3:0]    nibbles [ADDR_NIBBLES];

    assign commit      = (cycle == COMMIT_CYCLE) && !reset;
    assign push        = commit && (control == MODE_CALL);
    assign pop         = commit && (control == MODE_RET);
    assign stack_full  = (depth_reg == DEPTH_MAX);
    assign stack_empty = (depth_reg == 4'd0);
    assign pc_inc      = pc_reg + AW'(1);
    assign ptr_inc     = (ptr_reg == PTR_LAST) ? 4'd0 : ptr_reg + 4'd1;
    assign ptr_dec     = (ptr_reg == 4'd0) ? PTR_LAST : ptr_reg - 4'd1;

    // Return address sits just below the write pointer, wrapping circularly.
    always_comb begin
        pop_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_dec == 4'(i)) begin
                pop_value = entry_reg[i];
            end
        end
    end

    always_comb begin
        pc_next    = pc_reg;
        ptr_next   = ptr_reg;
        depth_next = depth_reg;
        if (commit) begin
            case (control)
                MODE_INC:  pc_next = pc_inc;
                MODE_JUMP: pc_next = target;
                MODE_CALL: begin
                    pc_next  = target;
                    ptr_next = ptr_inc;
                    if (!stack_full) begin
                        depth_next = depth_reg + 4'd1;
                    end
                end
                MODE_RET: begin
                    pc_next  = pop_value;
                    ptr_next = ptr_dec;
                    if (!stack_empty) begin
                        depth_next = depth_reg - 4'd1;
                    end
                end
                default: pc_next = pc_reg;
            endcase
        end
    end

    // A setting event on the same edge outranks clear_flags.
    assign overflow_next  = (push && stack_full) || (overflow_reg && !clear_flags);
    assign underflow_next = (pop && stack_empty) || (underflow_reg && !clear_flags);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg        <= '0;
            ptr_reg       <= 4'd0;
            depth_reg     <= 4'd0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            pc_reg        <= pc_next;
            ptr_reg       <= ptr_next;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ptr_reg == 4'(i)) begin
                    entry_reg[i] <= pc_inc;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ADDR_NIBBLES; gi++) begin : g_nibble
            assign nibbles[gi] = pc_reg[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        pc_enable = 1'b0;
        pc_word   = 4'd0;
        if (!reset && ({1'b0, cycle} < BUS_NIBBLES)) begin
            pc_enable = 1'b1;
            for (int i = 0; i < ADDR_NIBBLES; i++) begin
                if (cycle == 3'(i)) begin
                    pc_word = nibbles[i];
                end
            end
        end
    end

    assign pc        = pc_reg;
    assign depth     = depth_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_pc_call_stack.sv
// Directed bench for pc_call_stack: one table row per instruction, plus hand-built
// sequences for late target changes, reset during commit and standalone flag clearing.
module tb_pc_call_stack;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  cycle;
    logic [1:0]  control;
    logic [11:0] target;
    logic        clear_flags;
    logic [11:0] pc;
    logic        pc_enable;
    logic [3:0]  pc_word;
    logic [3:0]  depth;
    logic        overflow;
    logic        underflow;

    int tests = 0;
    int fails = 0;
    logic [11:0] cur_pc;

    typedef struct {
        logic [1:0]  ctl;
        logic [11:0] tgt;
        logic        clr;
        logic [11:0] exp_pc;
        logic [3:0]  exp_depth;
        logic        exp_ov;
        logic        exp_un;
    } vec_t;

    vec_t vecs[$];

    pc_call_stack #(
        .ADDR_NIBBLES(3),
        .DEPTH(3),
        .LAST_CYCLE(7)
    ) dut (
        .clock(clock),
        .reset(reset),
        .cycle(cycle),
        .control(control),
        .target(target),
        .clear_flags(clear_flags),
        .pc(pc),
        .pc_enable(pc_enable),
        .pc_word(pc_word),
        .depth(depth),
        .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] ctl, input logic [11:0] tgt, input logic clr,
                       input logic [11:0] epc, input logic [3:0] edep,
                       input logic eov, input logic eun);
        vec_t v;
        v.ctl = ctl; v.tgt = tgt; v.clr = clr;
        v.exp_pc = epc; v.exp_depth = edep; v.exp_ov = eov; v.exp_un = eun;
        vecs.push_back(v);
    endtask

    // One instruction: junk on control/target outside the commit subcycle, bus checked every subcycle.
    task automatic run_instr(input logic [1:0] ctl, input logic [11:0] tgt, input logic clr);
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            cycle = 3'(c);
            if (c == 7) begin
                control = ctl; target = tgt; clear_flags = clr;
            end else begin
                control = 2'($urandom); target = 12'($urandom); clear_flags = 1'b0;
            end
            #1;
            check("bus_enable", pc_enable, (c < 3) ? 1 : 0);
            check("bus_word", pc_word, (c < 3) ? cur_pc[4*c +: 4] : 4'd0);
            if (c == 7) check("pc_hold", pc, cur_pc);
        end
        @(posedge clock);
        #1;
        clear_flags = 1'b0;
        control = 2'b00;
    endtask

    task automatic check_state(input string tag, input logic [11:0] epc, input logic [3:0] edep,
                               input logic eov, input logic eun);
        check({tag, "_pc"}, pc, epc);
        check({tag, "_depth"}, depth, edep);
        check({tag, "_overflow"}, overflow, eov);
        check({tag, "_underflow"}, underflow, eun);
    endtask

    initial begin
        reset = 1'b1; cycle = 3'd0; control = 2'b00; target = 12'h000; clear_flags = 1'b0;
        cur_pc = 12'h000;

        // Increments, bus nibble order, all-ones wrap
        add(2'b00, 12'h000, 1'b0, 12'h001, 4'd0, 1'b0, 1'b0);
        add(2'b00, 12'h000, 1'b0, 12'h002, 4'd0, 1'b0, 1'b0);
        add(2'b00, 12'h000, 1'b0, 12'h003, 4'd0, 1'b0, 1'b0);
        add(2'b00, 12'h000, 1'b0, 12'h004, 4'd0, 1'b0, 1'b0);
        add(2'b01, 12'h123, 1'b0, 12'h123, 4'd0, 1'b0, 1'b0);
        add(2'b00, 12'h000, 1'b0, 12'h124, 4'd0, 1'b0, 1'b0);
        add(2'b01, 12'hFFF, 1'b0, 12'hFFF, 4'd0, 1'b0, 1'b0);
        add(2'b00, 12'h000, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);
        // Nested call/return
        add(2'b01, 12'h010, 1'b0, 12'h010, 4'd0, 1'b0, 1'b0);
        add(2'b10, 12'h400, 1'b0, 12'h400, 4'd1, 1'b0, 1'b0);
        add(2'b10, 12'h500, 1'b0, 12'h500, 4'd2, 1'b0, 1'b0);
        add(2'b11, 12'h000, 1'b0, 12'h401, 4'd1, 1'b0, 1'b0);
        add(2'b11, 12'h000, 1'b0, 12'h011, 4'd0, 1'b0, 1'b0);
        // Overflow: four calls into a three-deep stack
        add(2'b01, 12'h0A0, 1'b0, 12'h0A0, 4'd0, 1'b0, 1'b0);
        add(2'b10, 12'h0B0, 1'b0, 12'h0B0, 4'd1, 1'b0, 1'b0);
        add(2'b10, 12'h0C0, 1'b0, 12'h0C0, 4'd2, 1'b0, 1'b0);
        add(2'b10, 12'h0D0, 1'b0, 12'h0D0, 4'd3, 1'b0, 1'b0);
        add(2'b10, 12'h0E0, 1'b0, 12'h0E0, 4'd3, 1'b1, 1'b0);
        add(2'b11, 12'h000, 1'b0, 12'h0D1, 4'd2, 1'b1, 1'b0);
        add(2'b11, 12'h000, 1'b0, 12'h0C1, 4'd1, 1'b1, 1'b0);
        add(2'b11, 12'h000, 1'b0, 12'h0B1, 4'd0, 1'b1, 1'b0);
        add(2'b00, 12'h000, 1'b1, 12'h0B2, 4'd0, 1'b0, 1'b0);
        // Underflow wraps to the entry below the pointer; set beats same-edge clear
        add(2'b11, 12'h000, 1'b0, 12'h0D1, 4'd0, 1'b0, 1'b1);
        add(2'b00, 12'h000, 1'b1, 12'h0D2, 4'd0, 1'b0, 1'b0);
        add(2'b11, 12'h000, 1'b1, 12'h0C1, 4'd0, 1'b0, 1'b1);
        add(2'b00, 12'h000, 1'b1, 12'h0C2, 4'd0, 1'b0, 1'b0);

        repeat (2) @(posedge clock);
        #1;
        check("reset_enable", pc_enable, 0);
        check("reset_word", pc_word, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_state("reset", 12'h000, 4'd0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            run_instr(vecs[i].ctl, vecs[i].tgt, vecs[i].clr);
            $display("[TB] instr %0d ctl=%b tgt=%h clr=%b -> pc=%h depth=%0d ov=%b un=%b",
                     i, vecs[i].ctl, vecs[i].tgt, vecs[i].clr, pc, depth, overflow, underflow);
            check_state("table", vecs[i].exp_pc, vecs[i].exp_depth, vecs[i].exp_ov, vecs[i].exp_un);
            cur_pc = vecs[i].exp_pc;
        end

        // Target changes between cycle 4 and commit: only the cycle-7 value loads
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            cycle = 3'(c);
            case (c)
                4: begin control = 2'b01; target = 12'hABC; end
                5: target = 12'h321;
                6: target = 12'h777;
                7: target = 12'h5A5;
                default: begin control = 2'b00; target = 12'h000; end
            endcase
            @(posedge clock);
            #1;
            if (c == 4) check("late_target_hold", pc, 12'h0C2);
        end
        $display("[TB] late target jump -> pc=%h", pc);
        check("late_target_pc", pc, 12'h5A5);
        cur_pc = 12'h5A5;

        run_instr(2'b10, 12'h300, 1'b0);
        $display("[TB] call 300 -> pc=%h depth=%0d", pc, depth);
        check_state("call_pre_reset", 12'h300, 4'd1, 1'b0, 1'b0);
        cur_pc = 12'h300;

        // Reset dominates a call committing on the same edge
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            cycle = 3'(c);
            control = 2'b10;
            target = 12'h777;
            if (c == 7) reset = 1'b1;
        end
        @(posedge clock);
        #1;
        $display("[TB] reset during call -> pc=%h depth=%0d", pc, depth);
        check_state("reset_commit", 12'h000, 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        cycle = 3'd0;
        #1;
        check("reset_hold_enable", pc_enable, 0);
        check("reset_hold_word", pc_word, 0);
        @(negedge clock);
        reset = 1'b0;
        control = 2'b00;
        cur_pc = 12'h000;

        run_instr(2'b00, 12'h000, 1'b0);
        $display("[TB] post-reset inc -> pc=%h", pc);
        check_state("post_reset_inc", 12'h001, 4'd0, 1'b0, 1'b0);
        cur_pc = 12'h001;

        // Return on an empty, freshly reset stack loads a cleared entry
        run_instr(2'b11, 12'h000, 1'b0);
        $display("[TB] empty return -> pc=%h underflow=%b", pc, underflow);
        check_state("empty_return", 12'h000, 4'd0, 1'b0, 1'b1);
        cur_pc = 12'h000;

        // clear_flags on a non-commit edge
        @(negedge clock);
        cycle = 3'd3;
        clear_flags = 1'b1;
        @(posedge clock);
        #1;
        clear_flags = 1'b0;
        $display("[TB] clear pulse -> underflow=%b", underflow);
        check("clear_pulse_underflow", underflow, 0);
        check("clear_pulse_pc", pc, 12'h000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised program-counter and subroutine-return stack for the 4-bit CPU core.
- Drives the PC onto the shared 4-bit data bus one nibble per subcycle, least significant nibble first, during the address phase of each instruction.
- Updates the PC once per instruction at the boundary subcycle: increment, jump, call (push) or return (pop).
- Generalises the fixed 12-bit PC to N nibbles and a configurable-depth circular stack, with overflow/underflow flags and a depth readout.

Parameters:
- ADDR_NIBBLES, 3, PC width in nibbles; AW = 4*ADDR_NIBBLES; legal range 1..7.
- DEPTH, 3, number of return-address entries in the stack; legal range 1..15.
- LAST_CYCLE, 7, subcycle index on which the PC update is committed; must be >= ADDR_NIBBLES.

Ports:
- clock, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- cycle, input, 3, current instruction subcycle (0..7) from the control unit.
- control, input, 2, update mode: 00 increment, 01 jump, 10 call, 11 return.
- target, input, AW, jump/call destination; sampled only at commit.
- clear_flags, input, 1, clears the sticky overflow/underflow flags.
- pc, output, AW, current program counter.
- pc_enable, output, 1, high when pc_word must drive the data bus.
- pc_word, output, 4, PC nibble for the current subcycle.
- depth, output, 4, valid stack entries (0..DEPTH).
- overflow, output, 1, sticky: a call occurred while depth == DEPTH.
- underflow, output, 1, sticky: a return occurred while depth == 0.

Behaviour:
- Clock and reset:
  - Single clock domain; reset is synchronous and active-high, sampled on the rising clock edge.
  - On reset: pc = 0, stack write pointer = 0, depth = 0, overflow = 0, underflow = 0, all stack entries = 0.
  - While reset is high, pc_enable = 0 and pc_word = 0.
- Bus output (combinational from cycle and pc):
  - For cycle k < ADDR_NIBBLES: pc_enable = 1 and pc_word = pc[4k+3:4k].
  - For all other cycles: pc_enable = 0 and pc_word = 0.
- Commit:
  - State changes only on a clock edge where cycle == LAST_CYCLE and reset == 0.
  - On every other edge, pc, stack, pointer and depth hold.
  - PC therefore changes exactly once per instruction, and the new value is on the bus from the next subcycle 0.
- Update modes (all arithmetic modulo 2^AW):
  - 00 increment: pc <= pc + 1. All-ones wraps to 0.
  - 01 jump: pc <= target. Stack untouched.
  - 10 call: entry[ptr] <= pc + 1, ptr <= (ptr + 1) mod DEPTH, pc <= target.
    - If depth < DEPTH: depth increments.
    - If depth == DEPTH: depth stays DEPTH, the oldest entry is overwritten (circular), and overflow is set.
  - 11 return: ptr <= (ptr - 1) mod DEPTH, pc <= entry[(ptr - 1) mod DEPTH].
    - If depth > 0: depth decrements.
    - If depth == 0: depth stays 0, pc still loads the wrapped entry (deterministic 4004-style wrap), and underflow is set.
- Flags:
  - overflow and underflow are sticky until clear_flags or reset.
  - If clear_flags and a setting event occur on the same commit edge, the flag ends set.
  - clear_flags alone acts on any edge.
- Timing: no combinational path from target or control to any output; both affect outputs only after commit.
- Reset mid-instruction: reset dominates a commit in the same cycle. The next instruction fetch starts from address 0 once cycle returns to 0.

Test Plan:
- Reset then 4 instructions of control=00 → bus shows nibbles 0,0,0 then 1,0,0 then 2,0,0 then 3,0,0 in subcycles 0..2; pc_enable low in subcycles 3..7.
- Defaults; pc=0x123 with control=00 → pc_word 3,2,1 in cycles 0,1,2; pc=0xFFF with control=00 → pc=0x000, no flags set.
- Call 0x400 from pc=0x010, then call 0x500, then return, then return → pc goes 0x400, 0x500, 0x401, 0x011; depth goes 1, 2, 1, 0.
- Four calls with DEPTH=3, from pc values A, B, C, D → overflow=1, depth=3; three returns yield D+1, C+1, B+1 (A+1 is lost).
- Return at depth 0 → underflow=1, depth stays 0; a following clear_flags pulse → underflow=0.
- Drive control=01 with target=0xABC in cycle 4 and change target before cycle 7 → only the value present at cycle 7 loads. Assert reset in cycle 7 with control=10 → pc=0, depth=0, no push.
